// File: rtl/core_cache_pkg.sv
// Shared types and helpers for the cache line bridge.
package core_cache_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned BEAT_W     = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWrBeat,
        StRdIssue,
        StRdDrain,
        StRdDone
    } bridge_state_e;

    // Word address of one beat: line index with the beat number appended.
    // Line is passed zero-extended; callers keep only the bits they need.
    function automatic logic [63:0] word_addr(input logic [61:0]       line,
                                              input logic [BEAT_W-1:0] beat);
        return {line, beat};
    endfunction

endpackage

// File: rtl/core_cache_line_asm.sv
// Four-word line register filled one 32-bit word at a time through a 2-bit pointer.
module core_cache_line_asm
    import core_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [31:0]       word,
    output logic [127:0]      line,
    output logic [BEAT_W-1:0] ptr
);

    logic [31:0]       words_q [LINE_WORDS];
    logic [BEAT_W-1:0] ptr_q;

    // Write pointer and word storage; clear restarts assembly at word 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr_q <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else if (load) begin
            words_q[ptr_q] <= word;
            ptr_q          <= ptr_q + 2'd1;
        end
    end

    // Word 0 sits in the low 32 bits of the line.
    always_comb begin
        line = {words_q[3], words_q[2], words_q[1], words_q[0]};
        ptr  = ptr_q;
    end

endmodule

// File: rtl/core_cache_line_bridge.sv
// Splits 128-bit cache line reads and write-backs into four 32-bit memory beats
// and reassembles read beats into a line.
module core_cache_line_bridge
    import core_cache_pkg::*;
#(
    parameter int unsigned line_aw         = 23,
    parameter int unsigned max_outstanding = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [line_aw+2:0] i_c_addr,
    input  logic [3:0]         i_c_byte_en,
    input  logic [127:0]       i_c_writedata,
    input  logic               i_c_read,
    input  logic               i_c_write,
    output logic [127:0]       o_c_readdata,
    output logic               o_c_readdata_valid,
    output logic               o_c_waitrequest,
    output logic [line_aw+1:0] o_mem_addr,
    output logic [3:0]         o_mem_byte_en,
    output logic [31:0]        o_mem_writedata,
    output logic               o_mem_read,
    output logic               o_mem_write,
    input  logic [31:0]        i_mem_readdata,
    input  logic               i_mem_readdata_valid,
    input  logic               i_mem_waitrequest
);

    bridge_state_e     state_q, state_d;
    logic [line_aw-1:0] line_q;
    logic [3:0]        byte_en_q;
    logic [127:0]      wdata_q;
    logic [BEAT_W-1:0] wbeat_q, ibeat_q;
    logic [2:0]        outstanding_q, outstanding_d;
    logic [127:0]      readdata_q;

    logic              accept_wr, accept_rd;
    logic              ret, last_ret;
    logic              issue_ok, issue_fire, wr_fire;
    logic [BEAT_W-1:0] rbeat;
    logic [127:0]      asm_line;
    logic [BEAT_W-1:0] beat_sel;
    logic [63:0]       addr_full;
    logic              unused_bits;

    core_cache_line_asm u_line_asm (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept_rd),
        .load (ret),
        .word (i_mem_readdata),
        .line (asm_line),
        .ptr  (rbeat)
    );

    // Request decode, beat handshakes and outstanding-read bookkeeping.
    always_comb begin
        // Write wins when both requests arrive together.
        accept_wr  = (state_q == StIdle) && i_c_write;
        accept_rd  = (state_q == StIdle) && i_c_read && !i_c_write;
        // Returns outside the read states are stale and dropped.
        ret        = ((state_q == StRdIssue) || (state_q == StRdDrain)) && i_mem_readdata_valid;
        last_ret   = ret && (rbeat == 2'd3);
        issue_ok   = (state_q == StRdIssue) && (outstanding_q < 3'(max_outstanding));
        issue_fire = issue_ok && !i_mem_waitrequest;
        wr_fire    = (state_q == StWrBeat) && !i_mem_waitrequest;

        outstanding_d = outstanding_q;
        if (issue_fire && !ret) begin
            outstanding_d = outstanding_q + 3'd1;
        end else if (!issue_fire && ret) begin
            outstanding_d = outstanding_q - 3'd1;
        end

        beat_sel  = (state_q == StWrBeat) ? wbeat_q : ibeat_q;
        addr_full = word_addr(62'(line_q), beat_sel);
    end

    assign unused_bits = ^{i_c_addr[2:0], addr_full[63:line_aw+2]};

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept_wr) begin
                    state_d = StWrBeat;
                end else if (accept_rd) begin
                    state_d = StRdIssue;
                end
            end
            StWrBeat: begin
                if (wr_fire && (wbeat_q == 2'd3)) begin
                    state_d = StIdle;
                end
            end
            StRdIssue: begin
                // With zero-latency memory the last word can return as beat 3 issues.
                if (issue_fire && (ibeat_q == 2'd3)) begin
                    state_d = last_ret ? StRdDone : StRdDrain;
                end
            end
            StRdDrain: begin
                if (last_ret) begin
                    state_d = StRdDone;
                end
            end
            StRdDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched request and beat counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            line_q        <= '0;
            byte_en_q     <= '0;
            wdata_q       <= '0;
            wbeat_q       <= '0;
            ibeat_q       <= '0;
            outstanding_q <= '0;
            readdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            if (accept_wr || accept_rd) begin
                line_q    <= i_c_addr[line_aw+2:3];
                byte_en_q <= i_c_byte_en;
                wdata_q   <= i_c_writedata;
                wbeat_q   <= '0;
                ibeat_q   <= '0;
            end
            if (wr_fire) begin
                wbeat_q <= wbeat_q + 2'd1;
            end
            if (issue_fire) begin
                ibeat_q <= ibeat_q + 2'd1;
            end
            // Publish the line only when complete so the previous line stays visible.
            if (last_ret) begin
                readdata_q <= {i_mem_readdata, asm_line[95:0]};
            end
        end
    end

    // Outputs; everything is forced quiet while reset is held.
    always_comb begin
        o_mem_addr         = '0;
        o_mem_byte_en      = '0;
        o_mem_writedata    = '0;
        o_mem_read         = 1'b0;
        o_mem_write        = 1'b0;
        o_c_waitrequest    = (state_q != StIdle) || rst;
        o_c_readdata       = rst ? '0 : readdata_q;
        o_c_readdata_valid = (state_q == StRdDone) && !rst;
        if (!rst) begin
            if (state_q == StWrBeat) begin
                o_mem_write     = 1'b1;
                o_mem_addr      = addr_full[line_aw+1:0];
                o_mem_byte_en   = byte_en_q;
                o_mem_writedata = wdata_q[32*wbeat_q +: 32];
            end else if (issue_ok) begin
                o_mem_read    = 1'b1;
                o_mem_addr    = addr_full[line_aw+1:0];
                o_mem_byte_en = byte_en_q;
            end
        end
    end

endmodule

// File: tb/tb_core_cache_line_bridge.sv
// Directed bench for core_cache_line_bridge: DUT a uses 4 outstanding reads, DUT b uses 1.
module tb_core_cache_line_bridge;

    localparam int unsigned LAW = 23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [LAW+2:0] c_addr, b_addr;
    logic [3:0]     c_be;
    logic [127:0]   c_wdata;
    logic           c_read, c_write, b_read;
    logic           mem_wait;
    logic           stray;

    logic [127:0]   a_rdata, b_rdata;
    logic           a_rvalid, b_rvalid, a_wait, b_wait;
    logic [LAW+1:0] a_maddr, b_maddr;
    logic [3:0]     a_mbe, b_mbe;
    logic [31:0]    a_mwdata, b_mwdata;
    logic           a_mread, a_mwrite, b_mread, b_mwrite;
    logic [31:0]    a_mrdata, b_mrdata;
    logic           a_mrvalid, b_mrvalid;

    int n_checks = 0;
    int n_pass   = 0;

    core_cache_line_bridge #(.line_aw(LAW), .max_outstanding(4)) dut_a (
        .clk                  (clk),
        .rst                  (rst),
        .i_c_addr             (c_addr),
        .i_c_byte_en          (c_be),
        .i_c_writedata        (c_wdata),
        .i_c_read             (c_read),
        .i_c_write            (c_write),
        .o_c_readdata         (a_rdata),
        .o_c_readdata_valid   (a_rvalid),
        .o_c_waitrequest      (a_wait),
        .o_mem_addr           (a_maddr),
        .o_mem_byte_en        (a_mbe),
        .o_mem_writedata      (a_mwdata),
        .o_mem_read           (a_mread),
        .o_mem_write          (a_mwrite),
        .i_mem_readdata       (a_mrdata),
        .i_mem_readdata_valid (a_mrvalid),
        .i_mem_waitrequest    (mem_wait)
    );

    core_cache_line_bridge #(.line_aw(LAW), .max_outstanding(1)) dut_b (
        .clk                  (clk),
        .rst                  (rst),
        .i_c_addr             (b_addr),
        .i_c_byte_en          (c_be),
        .i_c_writedata        (c_wdata),
        .i_c_read             (b_read),
        .i_c_write            (1'b0),
        .o_c_readdata         (b_rdata),
        .o_c_readdata_valid   (b_rvalid),
        .o_c_waitrequest      (b_wait),
        .o_mem_addr           (b_maddr),
        .o_mem_byte_en        (b_mbe),
        .o_mem_writedata      (b_mwdata),
        .o_mem_read           (b_mread),
        .o_mem_write          (b_mwrite),
        .i_mem_readdata       (b_mrdata),
        .i_mem_readdata_valid (b_mrvalid),
        .i_mem_waitrequest    (mem_wait)
    );

    // Memory models: fixed 3-cycle read latency, word = 0xA0 + beat number.
    logic [2:0] a_v = '0, b_v = '0;
    logic [1:0] a_b0 = '0, a_b1 = '0, a_b2 = '0;
    logic [1:0] b_b0 = '0, b_b1 = '0, b_b2 = '0;
    always @(posedge clk) begin
        a_v  <= {a_v[1:0], a_mread && !mem_wait};
        a_b0 <= a_maddr[1:0];
        a_b1 <= a_b0;
        a_b2 <= a_b1;
        b_v  <= {b_v[1:0], b_mread && !mem_wait};
        b_b0 <= b_maddr[1:0];
        b_b1 <= b_b0;
        b_b2 <= b_b1;
    end
    assign a_mrvalid = a_v[2] | stray;
    assign a_mrdata  = stray ? 32'hDEADBEEF : 32'hA0 + 32'(a_b2);
    assign b_mrvalid = b_v[2];
    assign b_mrdata  = 32'hA0 + 32'(b_b2);

    // Observation record filled by observe(); cycle 1 is the first cycle after acceptance.
    int             mon_n_issue, mon_n_write, mon_n_valid, mon_valid_cyc;
    int             mon_issue_cyc [8];
    logic [LAW+1:0] mon_issue_addr [8];
    logic [127:0]   mon_line;

    task automatic observe(input bit sel_b, input int cycles);
        mon_n_issue = 0; mon_n_write = 0; mon_n_valid = 0; mon_valid_cyc = -1;
        mon_line = '0;
        for (int c = 1; c <= cycles; c++) begin
            if ((sel_b ? b_mread : a_mread) && !mem_wait) begin
                if (mon_n_issue < 8) begin
                    mon_issue_cyc[mon_n_issue]  = c;
                    mon_issue_addr[mon_n_issue] = sel_b ? b_maddr : a_maddr;
                end
                mon_n_issue++;
            end
            if (!sel_b && a_mwrite && !mem_wait) mon_n_write++;
            if (sel_b ? b_rvalid : a_rvalid) begin
                mon_n_valid++;
                mon_valid_cyc = c;
                mon_line = sel_b ? b_rdata : a_rdata;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (a_wait !== 1'b1) $display("FAIL reset_wait: got %b want 1", a_wait); else n_pass++;
        n_checks++; if (a_mread !== 1'b0 || a_mwrite !== 1'b0) $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", a_mread, a_mwrite); else n_pass++;
        n_checks++; if (a_rvalid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_rvalid); else n_pass++;
        n_checks++; if (a_rdata !== 128'h0) $display("FAIL reset_rdata: got %h want 0", a_rdata); else n_pass++;
        n_checks++; if (a_maddr !== '0) $display("FAIL reset_addr: got %h want 0", a_maddr); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (a_wait !== 1'b0 || b_wait !== 1'b0) $display("FAIL reset_release_wait: got a=%b b=%b want 0 0", a_wait, b_wait); else n_pass++;
    endtask

    task automatic test_write();
        c_addr  = {23'h000010, 3'b000};
        c_wdata = 128'h44444444_33333333_22222222_11111111;
        c_be    = 4'hF;
        c_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (a_mwrite !== 1'b1) $display("FAIL wr_strobe[%0d]: got %b want 1", i, a_mwrite); else n_pass++;
            n_checks++; if (a_maddr !== 25'(32'h40 + i)) $display("FAIL wr_addr[%0d]: got %h want %h", i, a_maddr, 32'h40 + i); else n_pass++;
            n_checks++; if (a_mwdata !== 32'h11111111 * (i + 1)) $display("FAIL wr_data[%0d]: got %h want %h", i, a_mwdata, 32'h11111111 * (i + 1)); else n_pass++;
            n_checks++; if (a_mbe !== 4'hF) $display("FAIL wr_be[%0d]: got %h want f", i, a_mbe); else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (a_wait !== 1'b0 || a_mwrite !== 1'b0) $display("FAIL wr_done: got wait=%b wr=%b want 0 0", a_wait, a_mwrite); else n_pass++;
    endtask

    task automatic test_write_stall();
        int beats [6] = '{0, 1, 1, 1, 2, 3};
        bit waits [6] = '{0, 1, 1, 0, 0, 0};
        int acc = 0;
        c_addr  = {23'h000005, 3'b000};
        c_wdata = 128'hB0000003_B0000002_B0000001_B0000000;
        c_be    = 4'h3;
        c_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_wait = waits[i];
            n_checks++; if (a_mwrite !== 1'b1) $display("FAIL stall_strobe[%0d]: got %b want 1", i, a_mwrite); else n_pass++;
            n_checks++; if (a_maddr !== 25'(32'h14 + beats[i])) $display("FAIL stall_addr[%0d]: got %h want %h", i, a_maddr, 32'h14 + beats[i]); else n_pass++;
            n_checks++; if (a_mwdata !== 32'hB0000000 + beats[i]) $display("FAIL stall_data[%0d]: got %h want %h", i, a_mwdata, 32'hB0000000 + beats[i]); else n_pass++;
            if (a_mwrite && !mem_wait) acc++;
            @(negedge clk);
        end
        mem_wait = 1'b0;
        n_checks++; if (acc !== 4) $display("FAIL stall_beats: got %0d want 4", acc); else n_pass++;
        n_checks++; if (a_mwrite !== 1'b0 || a_wait !== 1'b0) $display("FAIL stall_done: got wr=%b wait=%b want 0 0", a_mwrite, a_wait); else n_pass++;
    endtask

    task automatic test_read_pipelined();
        c_addr = {23'h000020, 3'b000};
        c_be   = 4'hF;
        c_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_read = 1'b0;
        observe(1'b0, 12);
        n_checks++; if (mon_n_issue !== 4) $display("FAIL rd4_issues: got %0d want 4", mon_n_issue); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mon_issue_cyc[i] !== i + 1 || mon_issue_addr[i] !== 25'(32'h80 + i)) $display("FAIL rd4_issue[%0d]: got cyc=%0d addr=%h want cyc=%0d addr=%h", i, mon_issue_cyc[i], mon_issue_addr[i], i + 1, 32'h80 + i); else n_pass++;
        end
        n_checks++; if (mon_n_valid !== 1 || mon_valid_cyc !== 8) $display("FAIL rd4_valid: got n=%0d cyc=%0d want n=1 cyc=8", mon_n_valid, mon_valid_cyc); else n_pass++;
        n_checks++; if (mon_line !== 128'h000000A3_000000A2_000000A1_000000A0) $display("FAIL rd4_line: got %h want 000000a3000000a2000000a1000000a0", mon_line); else n_pass++;
        n_checks++; if (a_rdata !== 128'h000000A3_000000A2_000000A1_000000A0) $display("FAIL rd4_hold: got %h want 000000a3000000a2000000a1000000a0", a_rdata); else n_pass++;
        n_checks++; if (a_wait !== 1'b0) $display("FAIL rd4_idle: got %b want 0", a_wait); else n_pass++;
    endtask

    task automatic test_read_serial();
        int exp_cyc [4] = '{1, 5, 9, 13};
        b_addr = {23'h000020, 3'b000};
        b_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_read = 1'b0;
        observe(1'b1, 20);
        n_checks++; if (mon_n_issue !== 4) $display("FAIL rd1_issues: got %0d want 4", mon_n_issue); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mon_issue_cyc[i] !== exp_cyc[i] || mon_issue_addr[i] !== 25'(32'h80 + i)) $display("FAIL rd1_issue[%0d]: got cyc=%0d addr=%h want cyc=%0d addr=%h", i, mon_issue_cyc[i], mon_issue_addr[i], exp_cyc[i], 32'h80 + i); else n_pass++;
        end
        n_checks++; if (mon_n_valid !== 1 || mon_valid_cyc !== 17) $display("FAIL rd1_valid: got n=%0d cyc=%0d want n=1 cyc=17", mon_n_valid, mon_valid_cyc); else n_pass++;
        n_checks++; if (mon_line !== 128'h000000A3_000000A2_000000A1_000000A0) $display("FAIL rd1_line: got %h want 000000a3000000a2000000a1000000a0", mon_line); else n_pass++;
    endtask

    task automatic test_read_write_both();
        c_addr  = {23'h000007, 3'b000};
        c_wdata = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
        c_read  = 1'b1;
        c_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_read  = 1'b0;
        c_write = 1'b0;
        observe(1'b0, 8);
        n_checks++; if (mon_n_write !== 4) $display("FAIL both_writes: got %0d want 4", mon_n_write); else n_pass++;
        n_checks++; if (mon_n_issue !== 0) $display("FAIL both_reads: got %0d want 0", mon_n_issue); else n_pass++;
        n_checks++; if (mon_n_valid !== 0) $display("FAIL both_valid: got %0d want 0", mon_n_valid); else n_pass++;
        n_checks++; if (a_wait !== 1'b0) $display("FAIL both_idle: got %b want 0", a_wait); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        c_addr = {23'h000030, 3'b000};
        c_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_read = 1'b0;
        // Returns arrive in cycles 4 and 5; reset lands with two beats still in flight.
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (a_wait !== 1'b1) $display("FAIL mid_rst_wait: got %b want 1", a_wait); else n_pass++;
        n_checks++; if (a_mread !== 1'b0 || a_rvalid !== 1'b0 || a_maddr !== '0) $display("FAIL mid_rst_outs: got rd=%b v=%b addr=%h want 0 0 0", a_mread, a_rvalid, a_maddr); else n_pass++;
        rst   = 1'b0;
        stray = 1'b1;
        @(negedge clk);
        n_checks++; if (a_rdata !== 128'h0) $display("FAIL mid_rst_rdata: got %h want 0", a_rdata); else n_pass++;
        n_checks++; if (a_wait !== 1'b0 || a_rvalid !== 1'b0) $display("FAIL stray1: got wait=%b v=%b want 0 0", a_wait, a_rvalid); else n_pass++;
        @(negedge clk);
        n_checks++; if (a_wait !== 1'b0 || a_rvalid !== 1'b0) $display("FAIL stray2: got wait=%b v=%b want 0 0", a_wait, a_rvalid); else n_pass++;
        stray = 1'b0;
        c_addr = {23'h000021, 3'b000};
        c_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_read = 1'b0;
        observe(1'b0, 12);
        n_checks++; if (mon_n_issue !== 4 || mon_issue_addr[0] !== 25'h84 || mon_issue_addr[3] !== 25'h87) $display("FAIL post_rst_issue: got n=%0d a0=%h a3=%h want 4 84 87", mon_n_issue, mon_issue_addr[0], mon_issue_addr[3]); else n_pass++;
        n_checks++; if (mon_n_valid !== 1 || mon_valid_cyc !== 8) $display("FAIL post_rst_valid: got n=%0d cyc=%0d want n=1 cyc=8", mon_n_valid, mon_valid_cyc); else n_pass++;
        n_checks++; if (mon_line !== 128'h000000A3_000000A2_000000A1_000000A0) $display("FAIL post_rst_line: got %h want 000000a3000000a2000000a1000000a0", mon_line); else n_pass++;
    endtask

    initial begin
        rst      = 1'b1;
        c_addr   = '0;
        b_addr   = '0;
        c_be     = '0;
        c_wdata  = '0;
        c_read   = 1'b0;
        c_write  = 1'b0;
        b_read   = 1'b0;
        mem_wait = 1'b0;
        stray    = 1'b0;
        test_reset();
        test_write();
        test_write_stall();
        test_read_pipelined();
        test_read_serial();
        test_read_write_both();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
